eeprom_reader: RTL and testbench

Sequential reader for the on-board 8K×8 parallel EEPROM: it reads a programmed range of bytes back out. On a start command it walks an address range and drives the address, chip-enable and output-enable pins with programmable access and recovery waits. Each byte read is presented on a valid/ready stream, together with a running 8-bit checksum. It sits opposite the EEPROM programmer on the same pin bus and is used for boot-time load and write verification. The two blocks are never active together; the top-level mux owns the shared pins.

---
 rtl/eeprom_pkg.sv | 21 ++
 rtl/eeprom_reader_if.sv | 43 ++++
 rtl/eeprom_wait_timer.sv | 41 ++++
 rtl/eeprom_reader.sv | 156 +++++++++++++++
 tb/tb_eeprom_reader.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/eeprom_pkg.sv
// eeprom_pkg: definitions shared by the EEPROM reader and programmer.
//   EE_ADDR_W / EE_DATA_W : default pin-bus widths for the 8K x 8 part
//   EEPROM_DEPTH          : number of bytes in the array
//   TIMER_W               : width of the access/recovery wait counter
//   eeprom_rd_state_t     : reader FSM states
package eeprom_pkg;

    localparam int unsigned EE_ADDR_W    = 13;
    localparam int unsigned EE_DATA_W    = 8;
    localparam int unsigned EEPROM_DEPTH = 8192;
    localparam int unsigned TIMER_W      = 8;

    typedef enum logic [2:0] {
        StIdle,
        StAccess,
        StPresent,
        StRecover,
        StDone
    } eeprom_rd_state_t;

endpackage

// File: rtl/eeprom_reader_if.sv
// eeprom_reader_if: command, EEPROM pin and byte-stream signals of the reader.
//   command : start, start_addr, length -> busy, done, checksum
//   pins    : ee_addr, ee_ce_n, ee_oe_n, ee_we_n out; ee_data in
//   stream  : rd_data, rd_addr, rd_valid out; rd_ready in
// The slave modport is the reader's view; master is the controller/EEPROM side.
interface eeprom_reader_if
    import eeprom_pkg::*;
#(
    parameter int unsigned ADDR_W = EE_ADDR_W,
    parameter int unsigned DATA_W = EE_DATA_W
) ();

    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W:0]   length;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] checksum;

    logic [ADDR_W-1:0] ee_addr;
    logic [DATA_W-1:0] ee_data;
    logic              ee_ce_n;
    logic              ee_oe_n;
    logic              ee_we_n;

    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic              rd_ready;

    modport slave (
        input  start, start_addr, length, ee_data, rd_ready,
        output busy, done, checksum, ee_addr, ee_ce_n, ee_oe_n, ee_we_n,
               rd_data, rd_addr, rd_valid
    );

    modport master (
        output start, start_addr, length, ee_data, rd_ready,
        input  busy, done, checksum, ee_addr, ee_ce_n, ee_oe_n, ee_we_n,
               rd_data, rd_addr, rd_valid
    );

endinterface

// File: rtl/eeprom_wait_timer.sv
// eeprom_wait_timer: loadable down-counter that stops at zero.
//   clk, reset : clock, synchronous active-low reset
//   load_i     : load load_val_i this edge (wins over counting)
//   load_val_i : value to load
//   tc_o       : terminal count, high while the counter is zero
// Loading N-1 makes tc_o rise after N-1 edges, so a state that exits on tc_o
// lasts exactly N cycles counting the loading edge.
module eeprom_wait_timer
    import eeprom_pkg::*;
#(
    parameter int unsigned WIDTH = TIMER_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == '0);

endmodule

// File: rtl/eeprom_reader.sv
// eeprom_reader: walks an address range of the parallel EEPROM and streams
// each byte out on a valid/ready handshake with a running 8-bit checksum.
//   clk, reset : clock, synchronous active-low reset
//   bus        : eeprom_reader_if.slave (command, EEPROM pins, byte stream)
// ACCESS_CYCLES: cycles with OE low before ee_data is sampled (>= 1).
// RECOVERY_CYCLES: cycles with OE high between reads (>= 1).
module eeprom_reader
    import eeprom_pkg::*;
#(
    parameter int unsigned ADDR_W          = EE_ADDR_W,
    parameter int unsigned DATA_W          = EE_DATA_W,
    parameter int unsigned ACCESS_CYCLES   = 8,
    parameter int unsigned RECOVERY_CYCLES = 2
) (
    input logic             clk,
    input logic             reset,
    eeprom_reader_if.slave  bus
);

    localparam logic [TIMER_W-1:0] AccLoad = TIMER_W'(ACCESS_CYCLES - 1);
    localparam logic [TIMER_W-1:0] RecLoad = TIMER_W'(RECOVERY_CYCLES - 1);

    eeprom_rd_state_t  state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   remain_q, remain_d;
    logic [DATA_W-1:0] checksum_q, checksum_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_valid_q, rd_valid_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;

    logic               timer_load;
    logic [TIMER_W-1:0] timer_val;
    logic               timer_tc;

    eeprom_wait_timer #(
        .WIDTH (TIMER_W)
    ) u_wait_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .tc_o       (timer_tc)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        checksum_d = checksum_q;
        rd_data_d  = rd_data_q;
        rd_addr_d  = rd_addr_q;
        rd_valid_d = rd_valid_q;
        ce_n_d     = ce_n_q;
        oe_n_d     = oe_n_q;
        timer_load = 1'b0;
        timer_val  = AccLoad;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    checksum_d = '0;
                    if (bus.length != '0) begin
                        addr_d     = bus.start_addr;
                        remain_d   = bus.length;
                        ce_n_d     = 1'b0;
                        oe_n_d     = 1'b0;
                        timer_load = 1'b1;
                        timer_val  = AccLoad;
                        state_d    = StAccess;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StAccess: begin
                if (timer_tc) begin
                    rd_data_d  = bus.ee_data;
                    rd_addr_d  = addr_q;
                    rd_valid_d = 1'b1;
                    oe_n_d     = 1'b1;
                    state_d    = StPresent;
                end
            end
            StPresent: begin
                if (rd_valid_q && bus.rd_ready) begin
                    rd_valid_d = 1'b0;
                    checksum_d = checksum_q + rd_data_q;
                    remain_d   = remain_q - 1'b1;
                    // Natural ADDR_W overflow gives the 8191 -> 0 wrap.
                    addr_d     = addr_q + 1'b1;
                    timer_load = 1'b1;
                    timer_val  = RecLoad;
                    state_d    = StRecover;
                end
            end
            StRecover: begin
                if (timer_tc) begin
                    if (remain_q != '0) begin
                        oe_n_d     = 1'b0;
                        timer_load = 1'b1;
                        timer_val  = AccLoad;
                        state_d    = StAccess;
                    end else begin
                        ce_n_d  = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            remain_q   <= '0;
            checksum_q <= '0;
            rd_data_q  <= '0;
            rd_addr_q  <= '0;
            rd_valid_q <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            checksum_q <= checksum_d;
            rd_data_q  <= rd_data_d;
            rd_addr_q  <= rd_addr_d;
            rd_valid_q <= rd_valid_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
        end
    end

    assign bus.busy     = (state_q == StAccess) || (state_q == StPresent) ||
                          (state_q == StRecover);
    assign bus.done     = (state_q == StDone);
    assign bus.checksum = checksum_q;
    assign bus.ee_addr  = addr_q;
    assign bus.ee_ce_n  = ce_n_q;
    assign bus.ee_oe_n  = oe_n_q;
    assign bus.ee_we_n  = 1'b1;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_addr  = rd_addr_q;
    assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_eeprom_reader.sv
// tb_eeprom_reader: directed self-checking bench for eeprom_reader with an
// 8K x 8 EEPROM array model driving ee_data from ee_addr.
module tb_eeprom_reader;
    import eeprom_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    eeprom_reader_if bus ();

    logic [7:0] mem [0:8191];
    assign bus.ee_data = mem[bus.ee_addr];

    eeprom_reader u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit we_low_seen = 1'b0;

    always @(negedge clk) if (bus.ee_we_n !== 1'b1) we_low_seen = 1'b1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i <= max; i++) begin
            if (bus.rd_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_done(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i <= max; i++) begin
            if (bus.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Returns just after E0, with start already dropped.
    task automatic start_burst(input logic [12:0] a, input logic [13:0] len);
        bus.start_addr = a;
        bus.length     = len;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", bus.done); end
        n_cmp++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", bus.rd_valid); end
        n_cmp++; if (bus.rd_data !== 8'h00) begin n_err++; $display("FAIL rst_rd_data: got %h want 00", bus.rd_data); end
        n_cmp++; if (bus.rd_addr !== 13'h0) begin n_err++; $display("FAIL rst_rd_addr: got %h want 0", bus.rd_addr); end
        n_cmp++; if (bus.checksum !== 8'h00) begin n_err++; $display("FAIL rst_checksum: got %h want 00", bus.checksum); end
        n_cmp++; if (bus.ee_addr !== 13'h0) begin n_err++; $display("FAIL rst_ee_addr: got %h want 0", bus.ee_addr); end
        n_cmp++; if (bus.ee_ce_n !== 1'b1) begin n_err++; $display("FAIL rst_ce_n: got %b want 1", bus.ee_ce_n); end
        n_cmp++; if (bus.ee_oe_n !== 1'b1) begin n_err++; $display("FAIL rst_oe_n: got %b want 1", bus.ee_oe_n); end
        n_cmp++; if (bus.ee_we_n !== 1'b1) begin n_err++; $display("FAIL rst_we_n: got %b want 1", bus.ee_we_n); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bus.rd_ready = 1'b1;
        start_burst(13'h0010, 14'd1);
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", bus.busy); end
        n_cmp++; if (bus.ee_addr !== 13'h0010) begin n_err++; $display("FAIL single_ee_addr: got %h want 0010", bus.ee_addr); end
        n_cmp++; if (bus.ee_ce_n !== 1'b0) begin n_err++; $display("FAIL single_ce_n: got %b want 0", bus.ee_ce_n); end
        n_cmp++; if (bus.ee_oe_n !== 1'b0) begin n_err++; $display("FAIL single_oe_n: got %b want 0", bus.ee_oe_n); end
        repeat (7) tick();
        n_cmp++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid: got %b want 0", bus.rd_valid); end
        n_cmp++; if (bus.ee_oe_n !== 1'b0) begin n_err++; $display("FAIL single_oe_in_access: got %b want 0", bus.ee_oe_n); end
        tick();
        n_cmp++; if (bus.rd_valid !== 1'b1) begin n_err++; $display("FAIL single_valid_at_8: got %b want 1", bus.rd_valid); end
        n_cmp++; if (bus.rd_data !== 8'hA5) begin n_err++; $display("FAIL single_rd_data: got %h want a5", bus.rd_data); end
        n_cmp++; if (bus.rd_addr !== 13'h0010) begin n_err++; $display("FAIL single_rd_addr: got %h want 0010", bus.rd_addr); end
        n_cmp++; if (bus.ee_oe_n !== 1'b1) begin n_err++; $display("FAIL single_oe_after: got %b want 1", bus.ee_oe_n); end
        tick(); // handshake edge H
        n_cmp++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_clear: got %b want 0", bus.rd_valid); end
        tick();
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL single_done_early: got %b want 0", bus.done); end
        tick();
        n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL single_done: got %b want 1", bus.done); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL single_busy_done: got %b want 0", bus.busy); end
        n_cmp++; if (bus.checksum !== 8'hA5) begin n_err++; $display("FAIL single_checksum: got %h want a5", bus.checksum); end
        n_cmp++; if (bus.ee_ce_n !== 1'b1) begin n_err++; $display("FAIL single_ce_release: got %b want 1", bus.ee_ce_n); end
        tick();
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL single_done_pulse: got %b want 0", bus.done); end
        n_cmp++; if (bus.checksum !== 8'hA5) begin n_err++; $display("FAIL single_checksum_hold: got %h want a5", bus.checksum); end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp [4];
        bit ok;
        exp = '{8'h01, 8'h02, 8'h03, 8'hFF};
        bus.rd_ready = 1'b0;
        start_burst(13'h0000, 14'd4);
        for (int i = 0; i < 4; i++) begin
            wait_valid(30, ok);
            n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL bp_valid_timeout[%0d]: got %b want 1", i, ok); end
            n_cmp++; if (bus.rd_addr !== 13'(i)) begin n_err++; $display("FAIL bp_addr[%0d]: got %0d want %0d", i, bus.rd_addr, i); end
            n_cmp++; if (bus.rd_data !== exp[i]) begin n_err++; $display("FAIL bp_data[%0d]: got %h want %h", i, bus.rd_data, exp[i]); end
            if (i == 2) begin
                repeat (5) begin
                    tick();
                    n_cmp++; if (bus.rd_valid !== 1'b1) begin n_err++; $display("FAIL bp_stall_valid: got %b want 1", bus.rd_valid); end
                    n_cmp++; if (bus.rd_data !== 8'h03) begin n_err++; $display("FAIL bp_stall_data: got %h want 03", bus.rd_data); end
                    n_cmp++; if (bus.ee_oe_n !== 1'b1) begin n_err++; $display("FAIL bp_stall_oe_n: got %b want 1", bus.ee_oe_n); end
                end
            end
            bus.rd_ready = 1'b1;
            tick();
            bus.rd_ready = 1'b0;
        end
        wait_done(10, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL bp_done_timeout: got %b want 1", ok); end
        n_cmp++; if (bus.checksum !== 8'h05) begin n_err++; $display("FAIL bp_checksum: got %h want 05", bus.checksum); end
        tick();
    endtask

    task automatic test_wrap();
        logic [12:0] exp_a [4];
        logic [7:0]  exp_d [4];
        bit ok;
        exp_a = '{13'd8190, 13'd8191, 13'd0, 13'd1};
        exp_d = '{8'h11, 8'h22, 8'h01, 8'h02};
        bus.rd_ready = 1'b1;
        start_burst(13'd8190, 14'd4);
        for (int i = 0; i < 4; i++) begin
            wait_valid(30, ok);
            n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL wrap_valid_timeout[%0d]: got %b want 1", i, ok); end
            n_cmp++; if (bus.rd_addr !== exp_a[i]) begin n_err++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", i, bus.rd_addr, exp_a[i]); end
            n_cmp++; if (bus.rd_data !== exp_d[i]) begin n_err++; $display("FAIL wrap_data[%0d]: got %h want %h", i, bus.rd_data, exp_d[i]); end
            tick();
        end
        wait_done(10, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL wrap_done_timeout: got %b want 1", ok); end
        n_cmp++; if (bus.checksum !== 8'h36) begin n_err++; $display("FAIL wrap_checksum: got %h want 36", bus.checksum); end
        tick();
    endtask

    task automatic test_len0();
        start_burst(13'h0005, 14'd0);
        n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL len0_done: got %b want 1", bus.done); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL len0_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.ee_ce_n !== 1'b1) begin n_err++; $display("FAIL len0_ce_n: got %b want 1", bus.ee_ce_n); end
        n_cmp++; if (bus.ee_oe_n !== 1'b1) begin n_err++; $display("FAIL len0_oe_n: got %b want 1", bus.ee_oe_n); end
        n_cmp++; if (bus.checksum !== 8'h00) begin n_err++; $display("FAIL len0_checksum: got %h want 00", bus.checksum); end
        tick();
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL len0_done_pulse: got %b want 0", bus.done); end
        n_cmp++; if (bus.ee_ce_n !== 1'b1) begin n_err++; $display("FAIL len0_ce_n_after: got %b want 1", bus.ee_ce_n); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bus.rd_ready = 1'b1;
        start_burst(13'h0000, 14'd4);
        repeat (25) tick(); // E0+25: third byte's ACCESS window
        n_cmp++; if (bus.ee_oe_n !== 1'b0) begin n_err++; $display("FAIL mid_in_access: got %b want 0", bus.ee_oe_n); end
        reset = 1'b0;
        tick();
        n_cmp++; if (bus.ee_oe_n !== 1'b1) begin n_err++; $display("FAIL mid_oe_n: got %b want 1", bus.ee_oe_n); end
        n_cmp++; if (bus.ee_ce_n !== 1'b1) begin n_err++; $display("FAIL mid_ce_n: got %b want 1", bus.ee_ce_n); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b want 0", bus.rd_valid); end
        n_cmp++; if (bus.checksum !== 8'h00) begin n_err++; $display("FAIL mid_checksum: got %h want 00", bus.checksum); end
        reset = 1'b1;
        tick();
        start_burst(13'h0010, 14'd1);
        wait_valid(30, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL mid_fresh_timeout: got %b want 1", ok); end
        n_cmp++; if (bus.rd_data !== 8'hA5) begin n_err++; $display("FAIL mid_fresh_data: got %h want a5", bus.rd_data); end
        n_cmp++; if (bus.rd_addr !== 13'h0010) begin n_err++; $display("FAIL mid_fresh_addr: got %h want 0010", bus.rd_addr); end
        wait_done(10, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL mid_fresh_done: got %b want 1", ok); end
        n_cmp++; if (bus.checksum !== 8'hA5) begin n_err++; $display("FAIL mid_fresh_checksum: got %h want a5", bus.checksum); end
        tick();
    endtask

    task automatic test_start_busy();
        bit ok;
        bus.rd_ready = 1'b1;
        start_burst(13'h0000, 14'd2);
        repeat (3) tick();
        bus.start_addr = 13'h0010;
        bus.length     = 14'd1;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        n_cmp++; if (bus.ee_addr !== 13'h0000) begin n_err++; $display("FAIL sb_addr_kept: got %h want 0000", bus.ee_addr); end
        for (int i = 0; i < 2; i++) begin
            wait_valid(30, ok);
            n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL sb_valid_timeout[%0d]: got %b want 1", i, ok); end
            n_cmp++; if (bus.rd_addr !== 13'(i)) begin n_err++; $display("FAIL sb_addr[%0d]: got %0d want %0d", i, bus.rd_addr, i); end
            n_cmp++; if (bus.rd_data !== 8'(i + 1)) begin n_err++; $display("FAIL sb_data[%0d]: got %h want %h", i, bus.rd_data, i + 1); end
            tick();
        end
        wait_done(10, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL sb_done_timeout: got %b want 1", ok); end
        // start while done is high must also be ignored
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL sb_start_in_done: got %b want 0", bus.busy); end
        n_cmp++; if (bus.ee_ce_n !== 1'b1) begin n_err++; $display("FAIL sb_ce_n_idle: got %b want 1", bus.ee_ce_n); end
        n_cmp++; if (bus.checksum !== 8'h03) begin n_err++; $display("FAIL sb_checksum: got %h want 03", bus.checksum); end
        tick();
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL sb_still_idle: got %b want 0", bus.busy); end
    endtask

    task automatic test_we();
        n_cmp++; if (we_low_seen !== 1'b0) begin n_err++; $display("FAIL we_n_never_low: got %b want 0", we_low_seen); end
        n_cmp++; if (bus.ee_we_n !== 1'b1) begin n_err++; $display("FAIL we_n_final: got %b want 1", bus.ee_we_n); end
    endtask

    initial begin
        for (int a = 0; a < 8192; a++) mem[a] = 8'h00;
        mem[0]    = 8'h01;
        mem[1]    = 8'h02;
        mem[2]    = 8'h03;
        mem[3]    = 8'hFF;
        mem[16]   = 8'hA5;
        mem[8190] = 8'h11;
        mem[8191] = 8'h22;
        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.length     = '0;
        bus.rd_ready   = 1'b0;

        test_reset();
        test_single();
        test_backpressure();
        test_wrap();
        test_len0();
        test_reset_mid();
        test_start_busy();
        test_we();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
